// File: rtl/mdio_mem_read_responder_pkg.sv
// Shared types and default widths for the MDIO memory-read responder.
package mdio_rd_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        READ = 3'd2,
        RESP = 3'd3,
        COOL = 3'd4
    } rd_state_e;

    localparam int unsigned MDIO_ADDR_W   = 15;
    localparam int unsigned MDIO_SEL_W    = 7;
    localparam int unsigned MDIO_LANE_W   = 9;
    localparam int unsigned MDIO_LANE_NUM = 96;

endpackage

// File: rtl/mdio_mem_read_responder_if.sv
// Capture-memory read port: responder is master, memory/arbiter is slave.
interface mdio_mem_read_responder_if
    import mdio_rd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MDIO_ADDR_W,
    parameter int unsigned DATA_WIDTH = MDIO_LANE_NUM * MDIO_LANE_W
);
    logic                  mem_busy;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport master (
        input  mem_busy,
        input  mem_rd_data,
        output mem_rd_en,
        output mem_rd_addr
    );

    modport slave (
        output mem_busy,
        output mem_rd_data,
        input  mem_rd_en,
        input  mem_rd_addr
    );
endinterface

// File: rtl/mdio_lane_mux.sv
// Combinational lane extraction from a wide memory word, with out-of-range flag.
module mdio_lane_mux
    import mdio_rd_pkg::*;
#(
    parameter int unsigned LANE_NUM   = MDIO_LANE_NUM,
    parameter int unsigned LANE_WIDTH = MDIO_LANE_W,
    parameter int unsigned SEL_WIDTH  = MDIO_SEL_W
) (
    input  logic [LANE_NUM*LANE_WIDTH-1:0] word,
    input  logic [SEL_WIDTH-1:0]           sel,
    output logic [LANE_WIDTH-1:0]          lane_c,
    output logic                           sel_err_c
);

    // Out-of-range selects return zero.
    always_comb begin
        lane_c    = '0;
        sel_err_c = (32'(sel) >= LANE_NUM);
        for (int k = 0; k < int'(LANE_NUM); k++) begin
            if (32'(sel) == 32'(k)) begin
                lane_c = word[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/mdio_mem_read_responder.sv
// Answers MDIO memory-read requests: arbitrates for the capture memory, extracts
// one lane and returns it with a one-cycle valid, spaced by a cooldown window.
// Optional self-test path (returns addr XOR sel without touching memory) is
// enabled by defining MDIO_RD_SELF_TEST_EN.
module mdio_mem_read_responder
    import mdio_rd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MDIO_ADDR_W,
    parameter int unsigned SEL_WIDTH  = MDIO_SEL_W,
    parameter int unsigned LANE_NUM   = MDIO_LANE_NUM,
    parameter int unsigned LANE_WIDTH = MDIO_LANE_W,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                    pktctrl_clk,
    input  logic                    pktctrl_rstn,
    input  logic                    rf_mdio_read_pulse_sync,
    input  logic [ADDR_WIDTH-1:0]   rf_mdio_memory_addr_sync,
    input  logic [SEL_WIDTH-1:0]    rf_mdio_data_sel_sync,
    input  logic                    rf_capture_start_sync,
    input  logic                    rf_self_test_mode_sync,
    mdio_mem_read_responder_if.master mem,
    output logic                    mdio_read_pulse_r,
    output logic [LANE_WIDTH-1:0]   rf_mdio_pkt_data,
    output logic                    rd_busy,
    output logic                    rd_drop_sticky,
    output logic                    rd_sel_err_sticky
);

    localparam int unsigned CNT_MAX = (GAP_CYCLES > RD_LATENCY) ? GAP_CYCLES : RD_LATENCY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    rd_state_e             state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [SEL_WIDTH-1:0]  lat_sel;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [SEL_WIDTH-1:0]  pend_sel;
    logic                  pend_v;
    logic                  st_path;

    logic                  st_sel_c;
    logic                  cool_done_c;
    logic                  promote_c;
    logic                  direct_c;
    logic                  queue_req_c;
    logic                  stash_c;
    logic                  drop_set_c;
    logic                  sel_err_set_c;
    logic [LANE_WIDTH-1:0] lane_c;
    logic                  lane_err_c;
    logic [LANE_WIDTH-1:0] st_data_c;

`ifdef MDIO_RD_SELF_TEST_EN
    assign st_sel_c = rf_self_test_mode_sync;
`else
    logic unused_self_test;
    assign unused_self_test = rf_self_test_mode_sync;
    assign st_sel_c         = 1'b0;
`endif

    mdio_lane_mux #(
        .LANE_NUM   (LANE_NUM),
        .LANE_WIDTH (LANE_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_lane_mux (
        .word      (mem.mem_rd_data),
        .sel       (lat_sel),
        .lane_c    (lane_c),
        .sel_err_c (lane_err_c)
    );

    // Memory strobe only while arbitrating and the writer has released the port.
    assign mem.mem_rd_en   = (state == ARB) && !mem.mem_busy && !st_sel_c;
    assign mem.mem_rd_addr = mem.mem_rd_en ? lat_addr : '0;
    assign rd_busy         = (state != IDLE);
    assign st_data_c       = LANE_WIDTH'(lat_addr) ^ LANE_WIDTH'(lat_sel);

    // Request routing: direct latch, stash into pending slot, or drop.
    always_comb begin
        cool_done_c   = (state == COOL) && (cnt == '0);
        promote_c     = cool_done_c && pend_v;
        direct_c      = rf_mdio_read_pulse_sync &&
                        ((state == IDLE) || (cool_done_c && !pend_v));
        queue_req_c   = rf_mdio_read_pulse_sync && !direct_c;
        stash_c       = queue_req_c && (!pend_v || promote_c);
        drop_set_c    = queue_req_c && pend_v && !promote_c;
        sel_err_set_c = (state == RESP) && !st_path && lane_err_c;
    end

    // Read sequencer, pending slot and sticky flags.
    always_ff @(posedge pktctrl_clk or negedge pktctrl_rstn) begin
        if (!pktctrl_rstn) begin
            state             <= IDLE;
            cnt               <= '0;
            lat_addr          <= '0;
            lat_sel           <= '0;
            pend_addr         <= '0;
            pend_sel          <= '0;
            pend_v            <= 1'b0;
            st_path           <= 1'b0;
            mdio_read_pulse_r <= 1'b0;
            rf_mdio_pkt_data  <= '0;
            rd_drop_sticky    <= 1'b0;
            rd_sel_err_sticky <= 1'b0;
        end else begin
            mdio_read_pulse_r <= 1'b0;
            rd_drop_sticky    <= drop_set_c    || (rd_drop_sticky    && !rf_capture_start_sync);
            rd_sel_err_sticky <= sel_err_set_c || (rd_sel_err_sticky && !rf_capture_start_sync);

            if (stash_c) begin
                pend_v    <= 1'b1;
                pend_addr <= rf_mdio_memory_addr_sync;
                pend_sel  <= rf_mdio_data_sel_sync;
            end else if (promote_c) begin
                pend_v    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (direct_c) begin
                        lat_addr <= rf_mdio_memory_addr_sync;
                        lat_sel  <= rf_mdio_data_sel_sync;
                        state    <= ARB;
                    end
                end
                ARB: begin
                    if (st_sel_c) begin
                        rf_mdio_pkt_data  <= st_data_c;
                        mdio_read_pulse_r <= 1'b1;
                        st_path           <= 1'b1;
                        state             <= RESP;
                    end else if (mem.mem_rd_en) begin
                        if (RD_LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            cnt   <= CNT_W'(RD_LATENCY - 1);
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (cnt <= CNT_W'(1)) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (!st_path) begin
                        rf_mdio_pkt_data  <= lane_c;
                        mdio_read_pulse_r <= 1'b1;
                    end
                    st_path <= 1'b0;
                    cnt     <= CNT_W'(GAP_CYCLES - 1);
                    state   <= COOL;
                end
                COOL: begin
                    if (cnt == '0) begin
                        if (pend_v) begin
                            lat_addr <= pend_addr;
                            lat_sel  <= pend_sel;
                            state    <= ARB;
                        end else if (direct_c) begin
                            lat_addr <= rf_mdio_memory_addr_sync;
                            lat_sel  <= rf_mdio_data_sel_sync;
                            state    <= ARB;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_mem_read_responder.sv
// Self-checking bench for mdio_mem_read_responder: directed scenarios, a vector
// table for lane-select boundaries, and randomized traffic against a
// transaction-level model of the capture memory.
module tb_mdio_mem_read_responder;
    import mdio_rd_pkg::*;

    localparam int unsigned AW  = MDIO_ADDR_W;
    localparam int unsigned SW  = MDIO_SEL_W;
    localparam int unsigned LN  = MDIO_LANE_NUM;
    localparam int unsigned LW  = MDIO_LANE_W;
    localparam int unsigned DW  = LN * LW;
    localparam int unsigned RL  = 2;
    localparam int unsigned GAP = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          pulse = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [SW-1:0] sel = '0;
    logic          cap_start = 1'b0;
    logic          st_mode = 1'b0;
    logic          rp;
    logic [LW-1:0] rdata;
    logic          busy;
    logic          drop_s;
    logic          sel_s;

    mdio_mem_read_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    mdio_mem_read_responder #(
        .ADDR_WIDTH (AW), .SEL_WIDTH (SW), .LANE_NUM (LN), .LANE_WIDTH (LW),
        .RD_LATENCY (RL), .GAP_CYCLES (GAP)
    ) dut (
        .pktctrl_clk              (clk),
        .pktctrl_rstn             (rstn),
        .rf_mdio_read_pulse_sync  (pulse),
        .rf_mdio_memory_addr_sync (addr),
        .rf_mdio_data_sel_sync    (sel),
        .rf_capture_start_sync    (cap_start),
        .rf_self_test_mode_sync   (st_mode),
        .mem                      (mem_if),
        .mdio_read_pulse_r        (rp),
        .rf_mdio_pkt_data         (rdata),
        .rd_busy                  (busy),
        .rd_drop_sticky           (drop_s),
        .rd_sel_err_sticky        (sel_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Capture memory model: per-lane content from a hash, with directed overrides.
    logic [LW-1:0] ovr [logic [AW+SW-1:0]];

    function automatic logic [LW-1:0] lane_val(input logic [AW-1:0] a, input int k);
        logic [AW+SW-1:0] key;
        key = {a, SW'(k)};
        if (ovr.exists(key)) return ovr[key];
        return LW'((int'(a) * 31 + k * 17 + 3) ^ (int'(a) >> 2));
    endfunction

    function automatic logic [DW-1:0] build_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int k = 0; k < int'(LN); k++) w[k*LW +: LW] = lane_val(a, k);
        return w;
    endfunction

    function automatic logic [LW-1:0] expect_data(input logic [AW-1:0] a, input logic [SW-1:0] s);
        if (int'(s) >= int'(LN)) return '0;
        return lane_val(a, int'(s));
    endfunction

    // Two-cycle read pipeline; junk pattern when no read is landing.
    logic          s1_v = 1'b0;
    logic [AW-1:0] s1_a = '0;
    always @(posedge clk) begin
        s1_v <= mem_if.mem_rd_en;
        s1_a <= mem_if.mem_rd_addr;
        mem_if.mem_rd_data <= s1_v ? build_word(s1_a) : {LN{9'h0AB}};
    end

    // mem_busy source: forced level, or random when enabled.
    logic busy_force = 1'b0;
    logic rnd_busy_en = 1'b0;
    always @(posedge clk) begin
        #2;
        mem_if.mem_busy = rnd_busy_en ? ($urandom_range(0, 9) < 3) : busy_force;
    end

    // Event monitor sampled mid-cycle.
    typedef struct { int cyc; logic [AW-1:0] addr; } en_ev_t;
    typedef struct { int cyc; logic [LW-1:0] data; } ret_ev_t;
    en_ev_t  en_q[$];
    ret_ev_t ret_q[$];
    logic mon_en = 1'b0;
    logic prev_rp = 1'b0;

    always @(negedge clk) begin
        if (mon_en && rstn) begin
            if (mem_if.mem_rd_en) en_q.push_back(en_ev_t'{cyc, mem_if.mem_rd_addr});
            else chk("rd_addr_zero_when_idle", 32'(mem_if.mem_rd_addr), 32'(0));
            if (rp) begin
                ret_q.push_back(ret_ev_t'{cyc, rdata});
                chk("pulse_single_cycle", 32'(prev_rp), 32'(0));
            end
            prev_rp = rp;
        end else begin
            prev_rp = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic cap, output int c);
        tick(1);
        pulse = 1'b1; addr = a; sel = s; cap_start = cap; c = cyc;
        tick(1);
        pulse = 1'b0; cap_start = 1'b0;
    endtask

    task automatic clear_sticky();
        tick(1);
        cap_start = 1'b1;
        tick(1);
        cap_start = 1'b0;
    endtask

    task automatic wait_rets(input int n, input int budget);
        int g;
        g = 0;
        while (ret_q.size() < n && g < budget) begin
            tick(1);
            g++;
        end
        chk("return_count", 32'(ret_q.size()), 32'(n));
    endtask

    task automatic flush_queues();
        en_q.delete();
        ret_q.delete();
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [SW-1:0] sel;
        logic [LW-1:0] val;
        logic [LW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[6];
        int            c, c2, free_cyc;
        logic [LW-1:0] exp_q[$];
        logic [AW-1:0] exp_a[$];
        logic          any_err;

        vecs[0] = '{15'h0100, 7'd96,  9'h077, 9'h000, 1'b1};
        vecs[1] = '{15'h0101, 7'd127, 9'h066, 9'h000, 1'b1};
        vecs[2] = '{15'h0102, 7'd95,  9'h15A, 9'h15A, 1'b0};
        vecs[3] = '{15'h7FFF, 7'd0,   9'h0F3, 9'h0F3, 1'b0};
        vecs[4] = '{15'h0000, 7'd64,  9'h1FF, 9'h1FF, 1'b0};
        vecs[5] = '{15'h2A5A, 7'd1,   9'h101, 9'h101, 1'b0};

        // Reset state
        tick(3);
        chk("reset_pulse", 32'(rp), 32'(0));
        chk("reset_data", 32'(rdata), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_drop", 32'(drop_s), 32'(0));
        chk("reset_selerr", 32'(sel_s), 32'(0));
        chk("reset_rd_en", 32'(mem_if.mem_rd_en), 32'(0));
        chk("reset_rd_addr", 32'(mem_if.mem_rd_addr), 32'(0));
        rstn = 1'b1;
        mon_en = 1'b1;
        tick(2);

        // Basic read with latency and hold
        ovr[{15'h0012, 7'd5}] = 9'h1A5;
        flush_queues();
        send(15'h0012, 7'd5, 1'b0, c);
        wait_rets(1, 30);
        chk("t1_en_count", 32'(en_q.size()), 32'(1));
        if (en_q.size() > 0) begin
            chk("t1_en_cycle", 32'(en_q[0].cyc), 32'(c + 1));
            chk("t1_en_addr", 32'(en_q[0].addr), 32'h0012);
        end
        if (ret_q.size() > 0) begin
            chk("t1_ret_cycle", 32'(ret_q[0].cyc), 32'(c + 4));
            chk("t1_ret_data", 32'(ret_q[0].data), 32'h1A5);
        end
        tick(20);
        chk("t1_data_held", 32'(rdata), 32'h1A5);
        chk("t1_no_extra_ret", 32'(ret_q.size()), 32'(1));

        // Read held off by mem_busy
        flush_queues();
        busy_force = 1'b1;
        tick(2);
        send(15'h0234, 7'd3, 1'b0, c);
        tick(6);
        busy_force = 1'b0;
        free_cyc = cyc;
        wait_rets(1, 30);
        tick(GAP + 4);
        chk("t2_en_count", 32'(en_q.size()), 32'(1));
        if (en_q.size() > 0) chk("t2_en_cycle", 32'(en_q[0].cyc), 32'(free_cyc));
        if (ret_q.size() > 0 && en_q.size() > 0) begin
            chk("t2_ret_cycle", 32'(ret_q[0].cyc), 32'(en_q[0].cyc + 3));
            chk("t2_ret_data", 32'(ret_q[0].data), 32'(expect_data(15'h0234, 7'd3)));
        end

        // Back-to-back A, B, C: B queued, C dropped (clear in same cycle loses)
        flush_queues();
        send(15'h00AA, 7'd1, 1'b0, c);
        send(15'h00BB, 7'd2, 1'b0, c2);
        send(15'h00CC, 7'd3, 1'b1, c2);
        wait_rets(2, 80);
        tick(GAP + 20);
        chk("t3_ret_count", 32'(ret_q.size()), 32'(2));
        chk("t3_en_count", 32'(en_q.size()), 32'(2));
        if (en_q.size() >= 2) begin
            chk("t3_en_addr_a", 32'(en_q[0].addr), 32'h00AA);
            chk("t3_en_addr_b", 32'(en_q[1].addr), 32'h00BB);
        end
        if (ret_q.size() >= 2) begin
            chk("t3_data_a", 32'(ret_q[0].data), 32'(expect_data(15'h00AA, 7'd1)));
            chk("t3_data_b", 32'(ret_q[1].data), 32'(expect_data(15'h00BB, 7'd2)));
            chk("t3_spacing", 32'((ret_q[1].cyc - ret_q[0].cyc) >= int'(GAP + 1)), 32'(1));
        end
        chk("t3_drop_set", 32'(drop_s), 32'(1));
        clear_sticky();
        chk("t3_drop_cleared", 32'(drop_s), 32'(0));

        // Vector table: lane-select boundaries
        for (int i = 0; i < 6; i++) begin
            flush_queues();
            clear_sticky();
            if (int'(vecs[i].sel) < int'(LN)) ovr[{vecs[i].addr, vecs[i].sel}] = vecs[i].val;
            send(vecs[i].addr, vecs[i].sel, 1'b0, c);
            wait_rets(1, 30);
            if (ret_q.size() > 0) begin
                chk("tv_ret_cycle", 32'(ret_q[0].cyc), 32'(c + 4));
                chk("tv_ret_data", 32'(ret_q[0].data), 32'(vecs[i].exp_data));
            end
            chk("tv_sel_err", 32'(sel_s), 32'(vecs[i].exp_err));
            tick(GAP + 4);
        end

        // Reset during READ with a pending request
        flush_queues();
        tick(1);
        pulse = 1'b1; addr = 15'h0111; sel = 7'd7;
        tick(1);
        addr = 15'h0222; sel = 7'd8;
        tick(1);
        pulse = 1'b0;
        chk("t5_busy_before", 32'(busy), 32'(1));
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_pulse", 32'(rp), 32'(0));
        chk("t5_rst_data", 32'(rdata), 32'(0));
        chk("t5_rst_busy", 32'(busy), 32'(0));
        chk("t5_rst_rd_en", 32'(mem_if.mem_rd_en), 32'(0));
        chk("t5_rst_sticky", 32'({drop_s, sel_s}), 32'(0));
        tick(2);
        rstn = 1'b1;
        flush_queues();
        tick(40);
        chk("t5_no_ret_after", 32'(ret_q.size()), 32'(0));
        chk("t5_no_read_after", 32'(en_q.size()), 32'(0));

        // Randomized traffic with random mem_busy
        flush_queues();
        clear_sticky();
        any_err = 1'b0;
        rnd_busy_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int g;
            logic [AW-1:0] ra;
            logic [SW-1:0] rs;
            g = 0;
            while (ret_q.size() != exp_q.size() && g < 300) begin
                tick(1);
                g++;
            end
            chk("rnd_outstanding", 32'(ret_q.size()), 32'(exp_q.size()));
            tick($urandom_range(0, 10));
            ra = AW'($urandom);
            rs = SW'($urandom_range(0, 127));
            exp_q.push_back(expect_data(ra, rs));
            exp_a.push_back(ra);
            if (int'(rs) >= int'(LN)) any_err = 1'b1;
            send(ra, rs, 1'b0, c);
        end
        wait_rets(40, 400);
        rnd_busy_en = 1'b0;
        tick(GAP + 4);
        chk("rnd_en_count", 32'(en_q.size()), 32'(40));
        for (int i = 0; i < 40; i++) begin
            if (i < ret_q.size() && i < en_q.size()) begin
                chk("rnd_data", 32'(ret_q[i].data), 32'(exp_q[i]));
                chk("rnd_addr", 32'(en_q[i].addr), 32'(exp_a[i]));
                chk("rnd_latency", 32'(ret_q[i].cyc - en_q[i].cyc), 32'(RL + 1));
                if (i > 0) chk("rnd_spacing", 32'((ret_q[i].cyc - ret_q[i-1].cyc) >= int'(GAP + 1)), 32'(1));
            end
        end
        chk("rnd_drop", 32'(drop_s), 32'(0));
        chk("rnd_sel_err", 32'(sel_s), 32'(any_err));

`ifdef MDIO_RD_SELF_TEST_EN
        // Self-test path bypasses memory
        flush_queues();
        busy_force = 1'b1;
        st_mode = 1'b1;
        tick(2);
        send(15'h01F0, 7'h0F, 1'b0, c);
        wait_rets(1, 30);
        if (ret_q.size() > 0) begin
            chk("st_ret_cycle", 32'(ret_q[0].cyc), 32'(c + 2));
            chk("st_ret_data", 32'(ret_q[0].data), 32'h1FF);
        end
        tick(GAP + 4);
        chk("st_no_mem_read", 32'(en_q.size()), 32'(0));
        st_mode = 1'b0;
        busy_force = 1'b0;
`endif

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
